booth_mul_arbiter: RTL and testbench

Shares one radix-4 Booth 8x8 signed multiplier (the `PPG` partial-product generator plus a registered summation stage) between `N_REQ` requesters. Arbitration is round-robin. The block issues at most one operand pair per cycle into a 2-stage pipeline and returns each product on a single result port, tagged with the requester ID. It sits between the PE operand schedulers and the multiplier datapath. It is the only block that drives `PPG` inputs.

---
 rtl/booth_mul_arbiter.sv | 160 ++++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one radix-4 Booth 8x8 signed multiplier among N_REQ requesters.
// Latency: operands accepted in cycle t are registered at edge t+1; the product is valid after edge t+2.
// Backpressure: a stalled result (res_valid && !res_ready) freezes both stages and drops every req_ready bit.
module booth_mul_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [15:0]          res_data,
    output logic [IDW-1:0]       res_id,
    output logic                 busy
);

    logic               pipe_en;
    logic               hs;
    logic [N_REQ-1:0]   grant;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     cand;
    logic               found;
    logic [IDW-1:0]     last_q, last_d;

    logic [7:0]         op_a, op_b;
    logic [8:0]         b_ext;
    logic [2:0]         trip;
    logic [8:0]         mag;
    logic [8:0]         pp_raw [4];
    logic [3:0]         neg_d, neg_q;
    logic [11:0]        pp0_d, pp0_q;
    logic [9:0]         pp1_d, pp1_q;
    logic [9:0]         pp2_d, pp2_q;
    logic [9:0]         pp3_d, pp3_q;
    logic [IDW-1:0]     s1_id_q;
    logic               s1_valid_q;

    logic [16:0]        sum_d;
    logic               res_valid_q;
    logic [15:0]        res_data_q;
    logic [IDW-1:0]     res_id_q;

    assign pipe_en = !res_valid_q || res_ready;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDW'((int'(last_q) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Accept is qualified by a free pipeline and forced low while reset is held.
    always_comb begin
        req_ready = reset ? (grant & {N_REQ{pipe_en}}) : '0;
        hs        = |(req_valid & req_ready);
        last_d    = hs ? grant_idx : last_q;
    end

    // Booth PPG: each digit selects 0, a or 2a; negative digits are one's-complemented
    // here and the +1 is carried separately in neg. The inverted-sign MSBs plus the
    // constant added in stage 2 replace full sign extension of each partial product.
    always_comb begin
        op_a  = req_a[{grant_idx, 3'b000} +: 8];
        op_b  = req_b[{grant_idx, 3'b000} +: 8];
        b_ext = {op_b, 1'b0};
        trip  = '0;
        mag   = '0;
        neg_d = '0;
        for (int j = 0; j < 4; j++) begin
            trip = b_ext[2*j +: 3];
            case (trip)
                3'b001, 3'b010, 3'b101, 3'b110: mag = {op_a[7], op_a};
                3'b011, 3'b100:                 mag = {op_a, 1'b0};
                default:                        mag = '0;
            endcase
            neg_d[j]  = trip[2] & ~(trip[1] & trip[0]);
            pp_raw[j] = neg_d[j] ? ~mag : mag;
        end
        pp0_d = {~pp_raw[0][8], pp_raw[0][8], pp_raw[0][8], pp_raw[0]};
        pp1_d = {~pp_raw[1][8], pp_raw[1]};
        pp2_d = {~pp_raw[2][8], pp_raw[2]};
        pp3_d = {~pp_raw[3][8], pp_raw[3]};
    end

    // Arbitration pointer; starts at N_REQ-1 so requester 0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_q <= IDW'(N_REQ - 1);
        else        last_q <= last_d;
    end

    // Stage 1: capture partial products of the accepted pair.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            pp0_q      <= '0;
            pp1_q      <= '0;
            pp2_q      <= '0;
            pp3_q      <= '0;
            neg_q      <= '0;
        end else if (pipe_en) begin
            s1_valid_q <= hs;
            if (hs) begin
                s1_id_q <= grant_idx;
                pp0_q   <= pp0_d;
                pp1_q   <= pp1_d;
                pp2_q   <= pp2_d;
                pp3_q   <= pp3_d;
                neg_q   <= neg_d;
            end
        end
    end

    // Weighted sum of the partial products; 17'h15000 cancels the sign-extension offsets mod 2^17.
    always_comb begin
        sum_d = {5'b0, pp0_q}
              + {5'b0, pp1_q, 2'b0}
              + {3'b0, pp2_q, 4'b0}
              + {1'b0, pp3_q, 6'b0}
              + {16'b0, neg_q[0]}
              + {14'b0, neg_q[1], 2'b0}
              + {12'b0, neg_q[2], 4'b0}
              + {10'b0, neg_q[3], 6'b0}
              + 17'h15000;
    end

    // Stage 2: output register; data/id only move when a valid pair arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
        end else if (pipe_en) begin
            res_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                res_data_q <= sum_d[15:0];
                res_id_q   <= s1_id_q;
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = s1_valid_q || res_valid_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: scoreboard monitor plus one task per scenario.
// Inputs change 1 time unit after a rising edge; outputs are sampled before the next edge.
// The monitor pushes expected products on each handshake and pops them on each drain.
module tb_booth_mul_arbiter;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [15:0] res_data;
    logic [1:0]  res_id;
    logic        busy;

    int   n_checks = 0;
    int   n_bad = 0;
    int   n_results = 0;
    sb_t  sb_q[$];

    booth_mul_arbiter #(.N_REQ(4), .IDW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor, sampled mid-cycle while inputs are stable.
    logic signed [7:0] ma, mb;
    int                mp;
    sb_t               ent, got;
    always @(negedge clk) begin
        if (reset) begin
            if (res_valid && res_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_unexpected: got id=%0d data=%h, want no result", res_id, res_data);
                end else begin
                    got = sb_q.pop_front();
                    n_results++;
                    if (res_data !== got.data || res_id !== got.id) begin
                        n_bad++;
                        $display("FAIL sb_result: got id=%0d data=%h, want id=%0d data=%h",
                                 res_id, res_data, got.id, got.data);
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    ma = req_a[i*8 +: 8];
                    mb = req_b[i*8 +: 8];
                    mp = int'(ma) * int'(mb);
                    ent.id   = 2'(i);
                    ent.data = mp[15:0];
                    sb_q.push_back(ent);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        #1 reset = 1'b0;
        #2;
        n_checks++;
        if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_valid_busy: got %b%b want 00", res_valid, busy); end
        n_checks++;
        if (res_data !== 16'h0000 || res_id !== 2'd0) begin n_bad++; $display("FAIL rst_data_id: got %h/%0d want 0000/0", res_data, res_id); end
        req_valid = '0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        set_ops(0, 8'h80, 8'h80);
        req_valid = 4'b0001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL single_s1: got valid=%b busy=%b want 0/1", res_valid, busy); end
        tick();
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h4000 || res_id !== 2'd0)
            begin n_bad++; $display("FAIL single_res: got %b/%h/%0d want 1/4000/0", res_valid, res_data, res_id); end
        tick();
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_idle: got valid=%b busy=%b want 0/0", res_valid, busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  oh;
        logic [15:0] exp_d;
        int          j;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        sb_q.delete();
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_ops(i, 8'(i + 1), 8'hFD);
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (k < 5) begin
                oh = 4'b0001 << (k % 4);
                n_checks++;
                if (req_ready !== oh) begin n_bad++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, oh); end
            end
            @(posedge clk);
            #1;
            if (k == 4) req_valid = '0;
            if (k >= 1) begin
                j = (k - 1) % 4;
                exp_d = 16'(-3 * (j + 1));
                n_checks++;
                if (res_valid !== 1'b1 || res_id !== 2'(j) || res_data !== exp_d)
                    begin n_bad++; $display("FAIL rr_res%0d: got %b/%0d/%h want 1/%0d/%h", k, res_valid, res_id, res_data, j, exp_d); end
            end
        end
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        res_ready = 1'b1;
        set_ops(0, 8'h7F, 8'h80);
        req_valid = 4'b0001;
        tick();
        set_ops(1, 8'h05, 8'h07);
        req_valid = 4'b0010;
        res_ready = 1'b0;
        tick();
        set_ops(2, 8'h03, 8'h03);
        req_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready%0d: got %b want 0000", c, req_ready); end
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== 16'hC080 || res_id !== 2'd0 || busy !== 1'b1)
                begin n_bad++; $display("FAIL bp_hold%0d: got %b/%h/%0d/%b want 1/c080/0/1", c, res_valid, res_data, res_id, busy); end
            tick();
        end
        res_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_release_ready: got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h0023 || res_id !== 2'd1)
            begin n_bad++; $display("FAIL bp_second: got %b/%h/%0d want 1/0023/1", res_valid, res_data, res_id); end
        tick();
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h0009 || res_id !== 2'd2)
            begin n_bad++; $display("FAIL bp_third: got %b/%h/%0d want 1/0009/2", res_valid, res_data, res_id); end
        tick();
        n_checks++;
        if (res_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", res_valid); end
    endtask

    task automatic test_exhaustive();
        int r0;
        int w;
        r0 = n_results;
        res_ready = 1'b1;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                set_ops(2, 8'(a), 8'(b));
                req_valid = 4'b0100;
                #1;
                w = 0;
                while (!req_ready[2] && w < 8) begin
                    @(posedge clk);
                    #2;
                    w++;
                end
                if (w >= 8) begin
                    n_checks++;
                    n_bad++;
                    $display("FAIL exh_timeout: got no ready for a=%0d b=%0d, want ready", a, b);
                end
                @(posedge clk);
                #1;
            end
        end
        req_valid = '0;
        tick();
        tick();
        tick();
        n_checks++;
        if (n_results - r0 != 65536) begin n_bad++; $display("FAIL exh_count: got %0d want 65536", n_results - r0); end
    endtask

    task automatic test_fairness();
        int others;
        int waitc;
        int grants3;
        bit done3;
        others = 0;
        waitc = 0;
        grants3 = 0;
        done3 = 1'b0;
        set_ops(1, 8'h02, 8'h03);
        req_valid = 4'b0010;
        for (int c = 0; c < 120; c++) begin
            if (done3) begin
                req_valid[3] = 1'b0;
                done3 = 1'b0;
            end
            res_ready = ($urandom_range(0, 3) != 0);
            if (!req_valid[3] && $urandom_range(0, 1) == 1) begin
                set_ops(3, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                req_valid[3] = 1'b1;
                others = 0;
                waitc = 0;
            end
            #1;
            if (req_valid[3]) begin
                if (req_ready[3]) begin
                    grants3++;
                    done3 = 1'b1;
                    n_checks++;
                    if (others + 1 > 4) begin n_bad++; $display("FAIL fair_wait: got grant at handshake %0d want <= 4", others + 1); end
                end else begin
                    if (req_ready[1]) others++;
                    waitc++;
                    if (waitc > 40) begin
                        n_checks++;
                        n_bad++;
                        $display("FAIL fair_timeout: got %0d cycles without grant want <= 40", waitc);
                        req_valid[3] = 1'b0;
                    end
                end
            end
            tick();
        end
        req_valid = '0;
        res_ready = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (grants3 == 0) begin n_bad++; $display("FAIL fair_any: got %0d grants to req3 want > 0", grants3); end
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b1;
        set_ops(0, 8'h09, 8'h09);
        req_valid = 4'b0001;
        tick();
        set_ops(1, 8'h0B, 8'hF0);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        n_checks++;
        if (res_valid !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL mid_pre: got valid=%b busy=%b want 1/1", res_valid, busy); end
        reset = 1'b0;
        #1;
        sb_q.delete();
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== 16'h0000)
            begin n_bad++; $display("FAIL mid_clear: got %b/%b/%h want 0/0/0000", res_valid, busy, res_data); end
        for (int i = 0; i < 4; i++) set_ops(i, 8'(i + 2), 8'h11);
        req_valid = 4'hF;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_ready_rst: got %b want 0000", req_ready); end
        tick();
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001 || res_valid !== 1'b0) begin n_bad++; $display("FAIL mid_first: got %b/%b want 0001/0", req_ready, res_valid); end
        tick();
        req_valid = '0;
        n_checks++;
        if (res_valid !== 1'b0) begin n_bad++; $display("FAIL mid_stale: got %b want 0", res_valid); end
        tick();
        n_checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 16'h0022)
            begin n_bad++; $display("FAIL mid_res: got %b/%0d/%h want 1/0/0022", res_valid, res_id, res_data); end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        test_exhaustive();
        n_checks++;
        if (sb_q.size() != 0) begin n_bad++; $display("FAIL sb_leftover: got %0d pending want 0", sb_q.size()); end
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
